ff_register_file_nr_nw_be: RTL and testbench

- Multi-port flip-flop register file: NUM_READ registered read ports and NUM_WRITE byte-enabled write ports, with a full-content MemContent export.
- Adds a sequential clear engine that zeroes one row per cycle, a read-data hold when a read port is disabled, and deterministic multi-writer priority.
- Used as the generalised storage for accelerator register banks and weight buffers in the SCM family.

---
 rtl/scm_rf_pkg.sv | 12 +
 rtl/scm_rf_write_arbiter.sv | 34 +++
 rtl/ff_register_file_nr_nw_be.sv | 103 ++++++++++
 tb/tb_ff_register_file_nr_nw_be.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/scm_rf_pkg.sv
// Shared types and helpers for the SCM flip-flop register file.
package scm_rf_pkg;

    typedef enum logic {IDLE, CLEAR} clr_state_e;

    function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       be);
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/scm_rf_write_arbiter.sv
// Per-row byte selector: for each byte the highest-index matching write port wins.
module scm_rf_write_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_WRITE  = 2,
    parameter int ROW        = 0
) (
    input  logic                                    en_i,
    input  logic [NUM_WRITE-1:0]                    we_i,
    input  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0]    waddr_i,
    input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0]    wdata_i,
    input  logic [NUM_WRITE-1:0][DATA_WIDTH/8-1:0]  wbe_i,
    output logic [DATA_WIDTH/8-1:0]                 sel_be_o,
    output logic [DATA_WIDTH-1:0]                   sel_data_o
);
    localparam int NB = DATA_WIDTH / 8;

    // Ascending scan so a later (higher-index) port overrides earlier ones.
    always_comb begin
        sel_be_o   = '0;
        sel_data_o = '0;
        for (int p = 0; p < NUM_WRITE; p++) begin
            if (en_i && we_i[p] && (waddr_i[p] == ADDR_WIDTH'(ROW))) begin
                for (int b = 0; b < NB; b++) begin
                    if (wbe_i[p][b]) begin
                        sel_be_o[b]          = 1'b1;
                        sel_data_o[8*b +: 8] = wdata_i[p][8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ff_register_file_nr_nw_be.sv
// Multi-port byte-enabled flop register file with sequential clear sweep.
// Optional SCM_RF_WRITE_BYPASS_EN forwards same-cycle write data to reads.
module ff_register_file_nr_nw_be
    import scm_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NUM_READ-1:0]                        ReadEnable,
    input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0]        ReadAddr,
    output logic [NUM_READ-1:0][DATA_WIDTH-1:0]        ReadData,
    input  logic [NUM_WRITE-1:0]                       WriteEnable,
    input  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0]       WriteAddr,
    input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0]       WriteData,
    input  logic [NUM_WRITE-1:0][DATA_WIDTH/8-1:0]     WriteBE,
    input  logic                                       ClearReq,
    output logic                                       Busy,
    output logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0]   MemContent
);
    localparam int N_ROWS = 2**ADDR_WIDTH;
    localparam int NB     = DATA_WIDTH / 8;

    clr_state_e                           state_q, state_d;
    logic [ADDR_WIDTH-1:0]                cnt_q, cnt_d;
    logic [N_ROWS-1:0][DATA_WIDTH-1:0]    mem_q, mem_d, rsrc;
    logic [NUM_READ-1:0][DATA_WIDTH-1:0]  rdata_q;
    logic [N_ROWS-1:0][NB-1:0]            sel_be;
    logic [N_ROWS-1:0][DATA_WIDTH-1:0]    sel_data;

    function automatic logic [DATA_WIDTH-1:0] merge_row(input logic [DATA_WIDTH-1:0] old_w,
                                                        input logic [DATA_WIDTH-1:0] new_w,
                                                        input logic [NB-1:0]         be);
        logic [DATA_WIDTH-1:0] r;
        for (int b = 0; b < NB; b++)
            r[8*b +: 8] = byte_merge(old_w[8*b +: 8], new_w[8*b +: 8], be[b]);
        return r;
    endfunction

    assign Busy = (state_q == CLEAR);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (ClearReq) begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_WIDTH{1'b1}}) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar r = 0; r < N_ROWS; r++) begin : g_row
        scm_rf_write_arbiter #(
            .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
            .NUM_WRITE(NUM_WRITE),   .ROW(r)
        ) u_arb (
            .en_i      (~Busy),
            .we_i      (WriteEnable),
            .waddr_i   (WriteAddr),
            .wdata_i   (WriteData),
            .wbe_i     (WriteBE),
            .sel_be_o  (sel_be[r]),
            .sel_data_o(sel_data[r])
        );
        // The sweep owns the row under the counter; writes are already gated off.
        assign mem_d[r] = (Busy && cnt_q == ADDR_WIDTH'(r)) ? '0
                        : merge_row(mem_q[r], sel_data[r], sel_be[r]);
    end

`ifdef SCM_RF_WRITE_BYPASS_EN
    assign rsrc = mem_d;
`else
    assign rsrc = mem_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mem_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
            for (int r = 0; r < NUM_READ; r++)
                if (ReadEnable[r]) rdata_q[r] <= rsrc[ReadAddr[r]];
        end
    end

    assign ReadData   = rdata_q;
    assign MemContent = mem_q;

endmodule

// File: tb/tb_ff_register_file_nr_nw_be.sv
// Directed scoreboard bench for ff_register_file_nr_nw_be (ADDR_WIDTH=3).
module tb_ff_register_file_nr_nw_be;
    localparam int AW = 3, DW = 64, NR = 2, NW = 2, ROWS = 8;

    logic                   clk = 1'b0, rst = 1'b1;
    logic [NR-1:0]          re = '0;
    logic [NR-1:0][AW-1:0]  ra = '0;
    logic [NR-1:0][DW-1:0]  rd;
    logic [NW-1:0]          we = '0;
    logic [NW-1:0][AW-1:0]  wa = '0;
    logic [NW-1:0][DW-1:0]  wd = '0;
    logic [NW-1:0][7:0]     wbe = '0;
    logic                   clr = 1'b0;
    logic                   busy;
    logic [ROWS-1:0][DW-1:0] mc;

    ff_register_file_nr_nw_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .NUM_WRITE(NW)) dut (
        .clk(clk), .rst(rst), .ReadEnable(re), .ReadAddr(ra), .ReadData(rd),
        .WriteEnable(we), .WriteAddr(wa), .WriteData(wd), .WriteBE(wbe),
        .ClearReq(clr), .Busy(busy), .MemContent(mc));

    always #5 clk = ~clk;

    typedef struct { int port; logic [DW-1:0] val; } exp_t;
    exp_t        sb[$];
    logic [DW-1:0] mdl [ROWS];
    logic [DW-1:0] mrd [NR];
    logic        mbusy = 1'b0;
    logic [AW-1:0] mcnt = '0;
    int n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_mem(input string tag);
        for (int r = 0; r < ROWS; r++) check($sformatf("%s_row%0d", tag, r), mc[r], mdl[r]);
    endtask

    // Reference model advances one clock, then the edge is taken and outputs compared.
    task automatic cycle();
        logic [DW-1:0] nm [ROWS];
        exp_t e;
        nm = mdl;
        if (rst) begin
            for (int r = 0; r < ROWS; r++) nm[r] = '0;
        end else if (mbusy) begin
            nm[mcnt] = '0;
        end else begin
            for (int p = 0; p < NW; p++)
                for (int b = 0; b < 8; b++)
                    if (we[p] && wbe[p][b]) nm[wa[p]][8*b +: 8] = wd[p][8*b +: 8];
        end
        for (int r = 0; r < NR; r++) begin
            if (rst) mrd[r] = '0;
`ifdef SCM_RF_WRITE_BYPASS_EN
            else if (re[r]) mrd[r] = nm[ra[r]];
`else
            else if (re[r]) mrd[r] = mdl[ra[r]];
`endif
            e.port = r; e.val = mrd[r];
            sb.push_back(e);
        end
        if (rst) begin
            mbusy = 1'b0; mcnt = '0;
        end else if (mbusy) begin
            if (mcnt == AW'(ROWS-1)) mbusy = 1'b0;
            mcnt = mcnt + 1'b1;
        end else if (clr) begin
            mbusy = 1'b1; mcnt = '0;
        end
        mdl = nm;
        @(posedge clk); #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("rdata%0d", e.port), rd[e.port], e.val);
        end
        check("busy", {63'd0, busy}, {63'd0, mbusy});
        we = '0; clr = 1'b0;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [7:0] be);
        we[p] = 1'b1; wa[p] = a; wd[p] = d; wbe[p] = be;
    endtask

    initial begin
        int bcnt;
        logic [DW-1:0] hold;
        for (int r = 0; r < ROWS; r++) mdl[r] = '0;
        for (int r = 0; r < NR; r++) mrd[r] = '0;

        cycle(); cycle();
        rst = 1'b0;
        check_mem("reset");

        re[0] = 1'b1; ra[0] = 3'd3;
        cycle();
        check("read3_after_reset", rd[0], 64'd0);

        wr(0, 3'd5, 64'h1111_2222_3333_4444, 8'hFF); cycle();
        wr(0, 3'd5, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F); cycle();
        check("row5_partial_be", mc[5], 64'h1111_2222_AAAA_AAAA);
        ra[0] = 3'd5; cycle();

        wr(0, 3'd7, 64'h1111_1111_1111_1111, 8'hFF);
        wr(1, 3'd7, 64'h2222_2222_2222_2222, 8'h01);
        cycle();
        check("row7_priority", mc[7], 64'h1111_1111_1111_1122);

        re[1] = 1'b1; ra[1] = 3'd7; cycle();
        hold = rd[1];
        re[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ra[1] = AW'(i);
            cycle();
            check("rd1_hold", rd[1], hold);
        end

        wr(1, 3'd2, 64'h0123_4567_89AB_CDEF, 8'hFF); cycle();
        re[0] = 1'b1; ra[0] = 3'd2;
        wr(0, 3'd2, 64'hFEDC_BA98_7654_3210, 8'hFF);
        wr(1, 3'd2, 64'h5555_5555_5555_5555, 8'h80);
        cycle();
`ifdef SCM_RF_WRITE_BYPASS_EN
        check("rw_same_addr", rd[0], 64'h55DC_BA98_7654_3210);
`else
        check("rw_same_addr", rd[0], 64'h0123_4567_89AB_CDEF);
`endif
        wr(0, 3'd6, 64'hDEAD_BEEF_0000_0006, 8'hFF); cycle();
        check_mem("pre_clear");

        // Sweep: write in the request cycle commits; mid-sweep write and re-request are ignored.
        re[1] = 1'b1; ra[1] = 3'd6;
        ra[0] = 3'd5;
        clr = 1'b1;
        wr(0, 3'd4, 64'h4444_4444_4444_4444, 8'hFF);
        bcnt = 0;
        cycle();
        if (busy) bcnt++;
        check_mem("clear_start");
        for (int i = 0; i < 12; i++) begin
            if (i == 2) wr(1, 3'd7, 64'h7777_7777_7777_7777, 8'hFF);
            if (i == 4) clr = 1'b1;
            cycle();
            if (busy) bcnt++;
        end
        check("busy_cycles", 64'(bcnt), 64'd8);
        check_mem("after_clear");

        wr(0, 3'd1, 64'h1, 8'hFF); wr(1, 3'd6, 64'h6, 8'hFF); cycle();
        clr = 1'b1; cycle();
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b1; cycle();
        rst = 1'b0;
        check("busy_after_rst", {63'd0, busy}, 64'd0);
        check_mem("after_rst");
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
